mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_pick.sv | 17 +
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, owner IDs and helpers for the memory arbiter.
//   IDLE/IFU_BUSY/LSU_BUSY : arbiter state encoding
//   OWN_IFU/OWN_LSU        : bit positions of each requester in the one-hot grant
//   CNT_MAX                : saturation value of the debug busy counter
//   ifu_word()             : selects the 32-bit instruction word from a 64-bit beat
package mem_arbiter_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IFU_BUSY = 2'd1;
    localparam logic [1:0] LSU_BUSY = 2'd2;

    localparam int OWN_IFU = 0;
    localparam int OWN_LSU = 1;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [31:0] ifu_word(input logic sel_hi, input logic [63:0] beat);
        return sel_hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational two-way picker producing a one-hot grant.
//   ifu_req, lsu_req : requests
//   ptr              : 0 favours LSU on a tie, 1 favours IFU
//   gnt              : one-hot grant, bit OWN_LSU / OWN_IFU
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt[OWN_LSU] = lsu_req & (~ifu_req | ~ptr);
    assign gnt[OWN_IFU] = ifu_req & (~lsu_req | ptr);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IFU fetches and LSU loads/stores onto one memory port.
//   clk, rstn                     : clock, asynchronous active-low reset
//   ifu_req/addr -> gnt/done/rdata: fetch requester (32-bit word from addr[2])
//   lsu_req/wen/addr/wdata/wlen   : load/store requester -> gnt/done/rdata
//   mm_req/wen/addr/wdata/wlen    : memory request, held until mm_ack
//   mm_ack/mm_rdata               : memory completion and read data
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is LSU-over-IFU.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ifu_req,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_gnt,
    output logic          ifu_done,
    output logic [31:0]   ifu_rdata,
    input  logic          lsu_req,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [3:0]    lsu_wlen,
    output logic          lsu_gnt,
    output logic          lsu_done,
    output logic [DW-1:0] lsu_rdata,
    output logic          mm_req,
    output logic          mm_wen,
    output logic [AW-1:0] mm_addr,
    output logic [DW-1:0] mm_wdata,
    output logic [3:0]    mm_wlen,
    input  logic          mm_ack,
    input  logic [DW-1:0] mm_rdata
);

    logic [1:0]  state;
    logic [1:0]  pick;
    logic        ptr;
    logic        idle;
    logic [15:0] busy_cnt;

    assign idle = state == IDLE;

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who won last so a tie next time goes to the other side.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr <= 1'b0;
        else if (idle && |pick)
            ptr <= pick[OWN_LSU];
    end
`else
    assign ptr = 1'b0;
`endif

    arb_pick u_pick (
        .ifu_req (ifu_req),
        .lsu_req (lsu_req),
        .ptr     (ptr),
        .gnt     (pick)
    );

    // Grants are combinational in IDLE; gating with rstn keeps them low in reset.
    assign ifu_gnt = rstn & idle & pick[OWN_IFU];
    assign lsu_gnt = rstn & idle & pick[OWN_LSU];

    // The mm_* registers double as the capture registers: they are loaded on
    // grant and only mm_req/mm_wen are cleared on completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mm_req    <= 1'b0;
            mm_wen    <= 1'b0;
            mm_addr   <= '0;
            mm_wdata  <= '0;
            mm_wlen   <= '0;
            ifu_done  <= 1'b0;
            lsu_done  <= 1'b0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
            busy_cnt  <= '0;
        end else begin
            ifu_done <= 1'b0;
            lsu_done <= 1'b0;
            if (idle) begin
                if (lsu_gnt) begin
                    state    <= LSU_BUSY;
                    mm_req   <= 1'b1;
                    mm_wen   <= lsu_wen;
                    mm_addr  <= lsu_addr;
                    mm_wdata <= lsu_wdata;
                    mm_wlen  <= lsu_wlen;
                    busy_cnt <= '0;
                end else if (ifu_gnt) begin
                    state    <= IFU_BUSY;
                    mm_req   <= 1'b1;
                    mm_wen   <= 1'b0;
                    mm_addr  <= ifu_addr;
                    busy_cnt <= '0;
                end
            end else begin
                if (busy_cnt != CNT_MAX)
                    busy_cnt <= busy_cnt + 16'd1;
                if (mm_ack) begin
                    state  <= IDLE;
                    mm_req <= 1'b0;
                    mm_wen <= 1'b0;
                    if (state == IFU_BUSY) begin
                        ifu_done  <= 1'b1;
                        ifu_rdata <= ifu_word(mm_addr[2], mm_rdata[63:0]);
                    end else begin
                        lsu_done  <= 1'b1;
                        lsu_rdata <= mm_wen ? '0 : mm_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ifu_req = 1'b0;
    logic [63:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_done;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_wen = 1'b0;
    logic [63:0] lsu_addr = '0;
    logic [63:0] lsu_wdata = '0;
    logic [3:0]  lsu_wlen = '0;
    logic        lsu_gnt, lsu_done;
    logic [63:0] lsu_rdata;
    logic        mm_req, mm_wen;
    logic [63:0] mm_addr, mm_wdata;
    logic [3:0]  mm_wlen;
    logic        mm_ack = 1'b0;
    logic [63:0] mm_rdata = '0;

    typedef struct {
        logic        lsu;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AW(64), .DW(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ifu_req   (ifu_req),
        .ifu_addr  (ifu_addr),
        .ifu_gnt   (ifu_gnt),
        .ifu_done  (ifu_done),
        .ifu_rdata (ifu_rdata),
        .lsu_req   (lsu_req),
        .lsu_wen   (lsu_wen),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_wlen  (lsu_wlen),
        .lsu_gnt   (lsu_gnt),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .mm_req    (mm_req),
        .mm_wen    (mm_wen),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_wlen   (mm_wlen),
        .mm_ack    (mm_ack),
        .mm_rdata  (mm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic lsu, input logic [63:0] rdata);
        exp_t e;
        e.lsu = lsu;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic check_done();
        exp_t e;
        chk("sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_pulse", {62'd0, lsu_done, ifu_done}, e.lsu ? 64'd2 : 64'd1);
            chk("done_rdata", e.lsu ? lsu_rdata : {32'd0, ifu_rdata}, e.rdata);
        end
    endtask

    // Called on the first negedge where mm_req should be up; holds off mm_ack
    // for w cycles while checking the request is stable, then acks once.
    task automatic serve(input int w, input logic [63:0] a, input logic wen,
                         input logic [63:0] wd, input logic [3:0] wl, input logic [63:0] rd);
        for (int i = 0; i <= w; i++) begin
            if (i > 0) @(negedge clk);
            chk("mm_req_held", {63'd0, mm_req}, 64'd1);
            chk("mm_addr", mm_addr, a);
            chk("mm_wen", {63'd0, mm_wen}, {63'd0, wen});
            if (wen) begin
                chk("mm_wdata", mm_wdata, wd);
                chk("mm_wlen", {60'd0, mm_wlen}, {60'd0, wl});
            end
        end
        mm_ack = 1'b1;
        mm_rdata = rd;
        @(negedge clk);
        mm_ack = 1'b0;
        mm_rdata = 64'hDEAD_0000_DEAD_0000;
        chk("mm_req_drop", {63'd0, mm_req}, 64'd0);
        chk("mm_wen_idle", {63'd0, mm_wen}, 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic        e_lsu;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mm_req", {63'd0, mm_req}, 64'd0);
        chk("rst_mm_addr", mm_addr, 64'd0);
        chk("rst_mm_wdata", mm_wdata, 64'd0);
        chk("rst_dones", {62'd0, ifu_done, lsu_done}, 64'd0);
        chk("rst_lsu_rdata", lsu_rdata, 64'd0);
        chk("rst_ifu_rdata", {32'd0, ifu_rdata}, 64'd0);

        // IFU read right after release, ack 3 cycles after mm_req
        rstn = 1'b1;
        ifu_req = 1'b1;
        ifu_addr = 64'h8000_0004;
        #1;
        chk("ifu_gnt_first", {62'd0, lsu_gnt, ifu_gnt}, 64'd1);
        push(1'b0, 64'h1111_2222);
        @(negedge clk);
        ifu_req = 1'b0;
        ifu_addr = 64'hFFFF_0000;
        serve(3, 64'h8000_0004, 1'b0, 64'd0, 4'd0, 64'h1111_2222_3333_4444);
        check_done();
        chk("busy_cnt", {48'd0, dut.busy_cnt}, 64'd4);
        @(negedge clk);
        chk("ifu_done_once", {63'd0, ifu_done}, 64'd0);

        // Simultaneous requests: LSU first, zero-wait, IFU granted on lsu_done
        ifu_req = 1'b1;
        ifu_addr = 64'h1000;
        lsu_req = 1'b1;
        lsu_wen = 1'b0;
        lsu_addr = 64'h48;
        #1;
        chk("tie_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd2);
        push(1'b1, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        lsu_req = 1'b0;
        lsu_addr = 64'h999;
        chk("busy_no_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd0);
        serve(0, 64'h48, 1'b0, 64'd0, 4'd0, 64'h0123_4567_89AB_CDEF);
        check_done();
        chk("b2b_ifu_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd1);
        push(1'b0, 64'h0BAD_F00D);
        @(negedge clk);
        ifu_req = 1'b0;
        serve(1, 64'h1000, 1'b0, 64'd0, 4'd0, 64'hFEED_FACE_0BAD_F00D);
        check_done();

        // LSU store: request stable until ack, lsu_rdata forced to 0
        lsu_req = 1'b1;
        lsu_wen = 1'b1;
        lsu_addr = 64'h100;
        lsu_wdata = 64'hDEAD_BEEF;
        lsu_wlen = 4'hF;
        #1;
        chk("st_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd2);
        push(1'b1, 64'd0);
        @(negedge clk);
        lsu_req = 1'b0;
        lsu_wen = 1'b0;
        lsu_addr = 64'h777;
        lsu_wdata = 64'd0;
        lsu_wlen = 4'd0;
        serve(2, 64'h100, 1'b1, 64'hDEAD_BEEF, 4'hF, 64'h5555_6666_7777_8888);
        check_done();
        chk("idle_addr_hold", mm_addr, 64'h100);
        chk("idle_wdata_hold", mm_wdata, 64'hDEAD_BEEF);
        chk("idle_wlen_hold", {60'd0, mm_wlen}, 64'hF);

        // mm_ack while idle is ignored
        @(negedge clk);
        mm_ack = 1'b1;
        mm_rdata = 64'hBAD;
        @(negedge clk);
        mm_ack = 1'b0;
        chk("idle_ack_req", {63'd0, mm_req}, 64'd0);
        chk("idle_ack_done", {62'd0, ifu_done, lsu_done}, 64'd0);
        chk("idle_ack_rdata", lsu_rdata, 64'd0);

        // Reset while LSU busy: abandon, then IFU granted right after release
        lsu_req = 1'b1;
        lsu_wen = 1'b1;
        lsu_addr = 64'h500;
        lsu_wdata = 64'h1;
        lsu_wlen = 4'h1;
        #1;
        chk("rst_lsu_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd2);
        @(negedge clk);
        lsu_req = 1'b0;
        ifu_req = 1'b1;
        ifu_addr = 64'h600C;
        chk("rst_busy_req", {63'd0, mm_req}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_req_drop", {63'd0, mm_req}, 64'd0);
        chk("async_addr_clr", mm_addr, 64'd0);
        @(negedge clk);
        chk("rst_no_done", {62'd0, ifu_done, lsu_done}, 64'd0);
        chk("rst_no_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd0);
        rstn = 1'b1;
        #1;
        chk("post_rst_gnt", {62'd0, lsu_gnt, ifu_gnt}, 64'd1);
        push(1'b0, 64'hAAAA_BBBB);
        @(negedge clk);
        ifu_req = 1'b0;
        chk("post_rst_no_lsu_done", {63'd0, lsu_done}, 64'd0);
        serve(1, 64'h600C, 1'b0, 64'd0, 4'd0, 64'hAAAA_BBBB_CCCC_DDDD);
        check_done();

        // Both requesting continuously
        ifu_req = 1'b1;
        ifu_addr = 64'h2004;
        lsu_req = 1'b1;
        lsu_wen = 1'b0;
        lsu_addr = 64'h3000;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            e_lsu = (k % 2) == 0;
`else
            e_lsu = 1'b1;
`endif
            rd = 64'h1000_0000_2000_0000 + 64'(k) * 64'h0101_0101_0101_0101;
            #1;
            chk("cont_gnt", {62'd0, lsu_gnt, ifu_gnt}, e_lsu ? 64'd2 : 64'd1);
            push(e_lsu, e_lsu ? rd : {32'd0, rd[63:32]});
            @(negedge clk);
            serve(0, e_lsu ? 64'h3000 : 64'h2004, 1'b0, 64'd0, 4'd0, rd);
            check_done();
            if (k == 3) begin
                ifu_req = 1'b0;
                lsu_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("final_idle_req", {63'd0, mm_req}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
